mem_arbiter: RTL and testbench

- Parametrised shared-memory front end. Lets N_PORTS requesters (default: port 0 = instruction fetch, port 1 = data) share one variable-latency backing memory or cache.
- Uses the existing cs/stall requester convention.
- Sits between the CPU core and a single memory/CMU, so instruction and data traffic no longer need separate memories.
- Adds arbitration (fixed-priority or round-robin), a req/ack memory handshake and per-port read-data holding.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter_rr_arbiter.sv | 39 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and arbitration modes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Pointer/index width; a single-port build still needs a 1-bit signal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter, bundled as one interface.
interface mem_arbiter_if #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_PORTS-1:0]            port_cs;
  logic [N_PORTS-1:0]            port_we;
  logic [N_PORTS*ADDR_WIDTH-1:0] port_addr;
  logic [N_PORTS*DATA_WIDTH-1:0] port_din;
  logic [N_PORTS*DATA_WIDTH-1:0] port_dout;
  logic [N_PORTS-1:0]            port_stall;
  logic                          mem_req;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_dout;
  logic [DATA_WIDTH-1:0]         mem_din;
  logic                          mem_ack;

  // Arbiter view.
  modport slave (
    input  port_cs, port_we, port_addr, port_din, mem_din, mem_ack,
    output port_dout, port_stall, mem_req, mem_we, mem_addr, mem_dout
  );

  // Environment view: requesters plus backing memory.
  modport master (
    output port_cs, port_we, port_addr, port_din, mem_din, mem_ack,
    input  port_dout, port_stall, mem_req, mem_we, mem_addr, mem_dout
  );
endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from a pointer, or lowest index first.
module rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               rr_mode,
  output logic [N_PORTS-1:0] grant
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (rr_mode) begin
        // Search upward from the pointer, wrapping past the top port.
        sum = {1'b0, ptr} + (PTR_W + 1)'(k);
        if (sum >= (PTR_W + 1)'(N_PORTS)) begin
          sum = sum - (PTR_W + 1)'(N_PORTS);
        end
        idx = sum[PTR_W-1:0];
      end else begin
        idx = PTR_W'(k);
      end
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory among N cs/stall requesters with a req/ack handshake
// and per-port registered read data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int PTR_W = ptr_width(N_PORTS);

  state_t                  state_reg, state_next;
  logic [N_PORTS-1:0]      grant_reg, grant_arb;
  logic [PTR_W-1:0]        ptr_reg, ptr_next, grant_idx;
  logic                    req_reg, we_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH-1:0]   pdout_reg [N_PORTS];
  logic [N_PORTS-1:0]      stall;
  logic                    load, capture, finish;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_din;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req     (bus.port_cs),
    .ptr     (ptr_reg),
    .rr_mode (RR_MODE == ARB_RR),
    .grant   (grant_arb)
  );

  // One-hot mux of the winning port's request fields.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_arb[i]) begin
        sel_we   = sel_we | bus.port_we[i];
        sel_addr = sel_addr | bus.port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = sel_din | bus.port_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_reg[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
    ptr_next = (grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|bus.port_cs) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          capture    = ~we_reg;
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      if (load) begin
        req_reg   <= 1'b1;
        we_reg    <= sel_we;
        addr_reg  <= sel_addr;
        wdata_reg <= sel_din;
        grant_reg <= grant_arb;
      end else if (finish) begin
        req_reg <= 1'b0;
      end
      if (state_reg == DONE && RR_MODE == ARB_RR) begin
        ptr_reg <= ptr_next;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      always_ff @(posedge clk) begin
        if (!rst) begin
          pdout_reg[gi] <= '0;
        end else if (capture && grant_reg[gi]) begin
          pdout_reg[gi] <= bus.mem_din;
        end
      end

      // Only the granted port gets its single stall-free cycle, and only in DONE.
      assign stall[gi] = bus.port_cs[gi] & ~((state_reg == DONE) & grant_reg[gi]);
      assign bus.port_dout[gi*DATA_WIDTH +: DATA_WIDTH] = pdout_reg[gi];
    end
  endgenerate

  assign bus.port_stall = stall;
  assign bus.mem_req    = req_reg;
  assign bus.mem_we     = we_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_dout   = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share one stimulus, each checked per cycle
// against a transaction-level model, plus directed literal checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  cs, we;
  logic [63:0] addr, din;
  int          lat;
  bit          noack, stray;
  int          total = 0;
  int          bad   = 0;

  logic [31:0] preload [logic [31:0]];

  logic [1:0]  stall_o [2];
  logic [63:0] pdout_o [2];
  logic        req_o   [2];
  logic        we_o    [2];
  logic [31:0] maddr_o [2];
  logic [31:0] mdout_o [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam bit RR = (gi == 0);

      mem_arbiter_if #(.N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

      logic [31:0] mem_din_v;
      logic        mem_ack_v;
      int          busy_cnt;
      logic [31:0] store [logic [31:0]];

      assign bus.port_cs   = cs;
      assign bus.port_we   = we;
      assign bus.port_addr = addr;
      assign bus.port_din  = din;
      assign bus.mem_din   = mem_din_v;
      assign bus.mem_ack   = mem_ack_v;

      mem_arbiter #(
        .N_PORTS    (2),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RR_MODE    (RR ? 1 : 0)
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );

      assign stall_o[gi] = bus.port_stall;
      assign pdout_o[gi] = bus.port_dout;
      assign req_o[gi]   = bus.mem_req;
      assign we_o[gi]    = bus.mem_we;
      assign maddr_o[gi] = bus.mem_addr;
      assign mdout_o[gi] = bus.mem_dout;

      // Backing memory: acks after lat cycles of a held request, one-cycle ack pulse.
      initial begin
        mem_din_v = 32'hA5A5_A5A5;
        mem_ack_v = 1'b0;
        busy_cnt  = 0;
      end
      always @(posedge clk) begin
        #2;
        mem_ack_v = 1'b0;
        mem_din_v = 32'hA5A5_A5A5;
        if (bus.mem_req === 1'b1 && !noack) begin
          busy_cnt++;
          if (busy_cnt == lat) begin
            mem_ack_v = 1'b1;
            if (bus.mem_we) begin
              store[bus.mem_addr] = bus.mem_dout;
            end else if (store.exists(bus.mem_addr)) begin
              mem_din_v = store[bus.mem_addr];
            end else if (preload.exists(bus.mem_addr)) begin
              mem_din_v = preload[bus.mem_addr];
            end else begin
              mem_din_v = 32'hBAD0_0000 | bus.mem_addr;
            end
          end
        end else begin
          busy_cnt = 0;
        end
        if (stray && bus.mem_req !== 1'b1) begin
          mem_ack_v = 1'b1;
          mem_din_v = 32'hFFFF_FFFF;
        end
      end

      // Transaction-level reference: who owns the memory, whether the access has been
      // acknowledged, what was latched, and the last read data delivered per port.
      int          owner;
      bit          acked;
      bit          m_req, m_we, started;
      logic [31:0] m_addr, m_wd;
      logic [31:0] m_pd [2];
      int          ptr;

      initial begin
        owner   = -1;
        acked   = 0;
        started = 0;
        ptr     = 0;
      end

      always @(negedge clk) begin
        if (started) begin
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("inst%0d stall[%0d]", gi, i), {63'd0, bus.port_stall[i]},
                {63'd0, cs[i] & ~(acked && owner == i)});
            chk($sformatf("inst%0d dout[%0d]", gi, i), {32'd0, bus.port_dout[i*32 +: 32]},
                {32'd0, m_pd[i]});
          end
          chk($sformatf("inst%0d mem_req", gi), {63'd0, bus.mem_req}, {63'd0, m_req});
          chk($sformatf("inst%0d mem_we", gi), {63'd0, bus.mem_we}, {63'd0, m_we});
          chk($sformatf("inst%0d mem_addr", gi), {32'd0, bus.mem_addr}, {32'd0, m_addr});
          chk($sformatf("inst%0d mem_dout", gi), {32'd0, bus.mem_dout}, {32'd0, m_wd});
        end
        // Advance the reference to the state after the coming rising edge.
        if (!rst) begin
          owner = -1; acked = 0; m_req = 0; m_we = 0; m_addr = '0; m_wd = '0;
          m_pd[0] = '0; m_pd[1] = '0; ptr = 0; started = 1;
        end else if (acked) begin
          if (RR) ptr = (owner + 1) % 2;
          acked = 0;
          owner = -1;
        end else if (owner < 0) begin
          for (int k = 0; k < 2; k++) begin
            int p;
            p = RR ? (ptr + k) % 2 : k;
            if (owner < 0 && cs[p]) owner = p;
          end
          if (owner >= 0) begin
            m_req  = 1;
            m_we   = we[owner];
            m_addr = addr[owner*32 +: 32];
            m_wd   = din[owner*32 +: 32];
          end
        end else if (mem_ack_v) begin
          if (!m_we) m_pd[owner] = mem_din_v;
          m_req = 0;
          acked = 1;
        end
      end
    end
  endgenerate

  // Requester: assert, wait for the stall-free cycle, advance on that edge.
  task automatic access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output bit saw_we);
    cs[p] = 1'b1; we[p] = w; addr[p*32 +: 32] = a; din[p*32 +: 32] = d;
    cyc = 0; saw_we = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      cyc++;
      if (req_o[0]) saw_we = saw_we | we_o[0];
      if (!stall_o[0][p]) break;
      step();
    end
    chk("access_done", {63'd0, stall_o[0][p]}, 64'd0);
    chk("access_done_inst1", {63'd0, stall_o[1][p]}, 64'd0);
    step();
    cs[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    bit          sw;
    logic [31:0] order [$];
    int          rises1, served1;
    bit          prev0, prev1;

    rst = 1'b0; cs = 2'b10; we = '0; addr = '0; din = '0;
    lat = 1; noack = 0; stray = 0;
    preload[32'h10]  = 32'hDEAD_BEEF;
    preload[32'h300] = 32'hCAFE_F00D;
    preload[32'h400] = 32'h4444_4444;
    preload[32'h500] = 32'h5555_5555;

    // Reset: stall mirrors cs, outputs cleared.
    step(); step();
    @(negedge clk);
    chk("reset_stall", {62'd0, stall_o[0]}, 64'h2);
    chk("reset_req", {63'd0, req_o[0]}, 64'd0);
    chk("reset_dout", pdout_o[1], 64'd0);
    step();
    cs = 2'b00; rst = 1'b1;
    step();

    // Single read by port 1, ack on first BUSY cycle.
    cs[1] = 1'b1; we[1] = 1'b0; addr[63:32] = 32'h10;
    @(negedge clk);
    chk("rd_c0_stall", {63'd0, stall_o[0][1]}, 64'd1);
    step();
    @(negedge clk);
    chk("rd_c1_stall", {63'd0, stall_o[0][1]}, 64'd1);
    chk("rd_c1_addr", {32'd0, maddr_o[0]}, 64'h10);
    step();
    @(negedge clk);
    chk("rd_c2_stall", {63'd0, stall_o[0][1]}, 64'd0);
    chk("rd_c2_dout1", {32'd0, pdout_o[0][63:32]}, 64'hDEAD_BEEF);
    chk("rd_c2_dout0", {32'd0, pdout_o[0][31:0]}, 64'd0);
    step();
    cs[1] = 1'b0;

    // Write then read-back, 4-cycle memory latency.
    lat = 4;
    access(1, 1'b1, 32'h20, 32'h1234_5678, cyc, sw);
    chk("wr_cycles", 64'(cyc), 64'd6);
    chk("wr_mem_we", {63'd0, sw}, 64'd1);
    chk("wr_dout_hold", {32'd0, pdout_o[0][63:32]}, 64'hDEAD_BEEF);
    access(1, 1'b0, 32'h20, 32'h0, cyc, sw);
    chk("rd_cycles", 64'(cyc), 64'd6);
    chk("rd_mem_we", {63'd0, sw}, 64'd0);
    chk("rd_back_inst0", {32'd0, pdout_o[0][63:32]}, 64'h1234_5678);
    chk("rd_back_inst1", {32'd0, pdout_o[1][63:32]}, 64'h1234_5678);

    // Contention: both ports hold cs; inst0 round-robin, inst1 fixed priority.
    lat = 1;
    cs = 2'b11; we = 2'b00; addr = {32'h200, 32'h100};
    prev0 = 0; prev1 = 0; rises1 = 0; served1 = 0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (req_o[0] && !prev0 && c < 12) order.push_back(maddr_o[0]);
      if (req_o[1] && !prev1 && maddr_o[1] == 32'h100) rises1++;
      if (!stall_o[1][1]) served1++;
      prev0 = req_o[0];
      prev1 = req_o[1];
      step();
    end
    chk("rr_count", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      chk($sformatf("rr_order%0d", k), {32'd0, order[k]}, (k % 2 == 0) ? 64'h100 : 64'h200);
    end
    chk("fp_port0_accesses", 64'(rises1), 64'd14);
    chk("fp_port1_starved", 64'(served1), 64'd0);
    cs[0] = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("fp_port1_req", {63'd0, req_o[1]}, 64'd1);
    chk("fp_port1_addr", {32'd0, maddr_o[1]}, 64'h200);
    step();
    @(negedge clk);
    chk("fp_port1_done", {63'd0, stall_o[1][1]}, 64'd0);
    step();
    cs = 2'b00;

    // Reset while BUSY with no ack.
    noack = 1;
    cs[0] = 1'b1; we[0] = 1'b0; addr[31:0] = 32'h300;
    step();
    @(negedge clk);
    chk("mid_req_before", {63'd0, req_o[0]}, 64'd1);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mid_req_after", {63'd0, req_o[0]}, 64'd0);
    chk("mid_dout_inst0", pdout_o[0], 64'd0);
    chk("mid_dout_inst1", pdout_o[1], 64'd0);
    step();
    rst = 1'b1; noack = 0;
    access(0, 1'b0, 32'h300, 32'h0, cyc, sw);
    chk("post_rst_cycles", 64'(cyc), 64'd3);
    chk("post_rst_dout", {32'd0, pdout_o[0][31:0]}, 64'hCAFE_F00D);

    // Stray ack while idle must not disturb anything.
    stray = 1;
    step(); step();
    stray = 0;
    @(negedge clk);
    chk("stray_dout", {32'd0, pdout_o[0][31:0]}, 64'hCAFE_F00D);

    // Abandoned read: port 0 drops cs in BUSY, port 1 waits.
    step();
    lat = 3;
    cs[0] = 1'b1; addr[31:0] = 32'h400;
    step();
    cs = 2'b10; addr[63:32] = 32'h500; we = 2'b00;
    @(negedge clk);
    chk("ab_addr", {32'd0, maddr_o[0]}, 64'h400);
    step(); step();
    @(negedge clk);
    chk("ab_req_held", {63'd0, req_o[0]}, 64'd1);
    step();
    @(negedge clk);
    chk("ab_dout0", {32'd0, pdout_o[0][31:0]}, 64'h4444_4444);
    chk("ab_port1_stalled", {63'd0, stall_o[0][1]}, 64'd1);
    step(); step();
    @(negedge clk);
    chk("ab_next_grant", {32'd0, maddr_o[0]}, 64'h500);
    chk("ab_next_grant_fp", {32'd0, maddr_o[1]}, 64'h500);
    for (int n = 0; n < 20 && stall_o[0][1]; n++) begin
      step();
      @(negedge clk);
    end
    chk("ab_port1_served", {63'd0, stall_o[0][1]}, 64'd0);
    chk("ab_dout1", {32'd0, pdout_o[0][63:32]}, 64'h5555_5555);
    step();
    cs = 2'b00;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
